// File: rtl/cic3_decim_ctrl_if.sv
// Downstream sample handshake bundle for cic3_decim_ctrl.
// CIC3_DECIM_CTRL_TIMESTAMP_EN adds the sample_seq tag.
interface cic3_decim_ctrl_if #(
    parameter int NUMBITS = 25
);
    logic [NUMBITS-1:0] sample_data;
    logic               sample_valid;
    logic               sample_ready;
    logic               overrun;
    logic               overrun_clr;
`ifdef CIC3_DECIM_CTRL_TIMESTAMP_EN
    logic [15:0]        sample_seq;

    modport master (output sample_data, sample_valid, overrun, sample_seq,
                    input  sample_ready, overrun_clr);
    modport slave  (input  sample_data, sample_valid, overrun, sample_seq,
                    output sample_ready, overrun_clr);
`else
    modport master (output sample_data, sample_valid, overrun,
                    input  sample_ready, overrun_clr);
    modport slave  (input  sample_data, sample_valid, overrun,
                    output sample_ready, overrun_clr);
`endif
endinterface

// File: rtl/cic3_decim_ctrl.sv
// Sequencing controller for a third-order CIC decimator: divider, settle discard,
// capture and valid/ready delivery. CIC3_DECIM_CTRL_TIMESTAMP_EN adds sample_seq.
module cic3_decim_ctrl #(
    parameter int DECIMATION_FACTOR = 256,
    parameter int CLOCK_WIDTH       = $clog2(DECIMATION_FACTOR),
    parameter int NUMBITS           = 3*CLOCK_WIDTH+1,
    parameter int SETTLE_SAMPLES    = 3,
    parameter int CAPTURE_DELAY     = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [NUMBITS-1:0] cic_out,
    output logic               divided_clk,
    output logic               busy,
    cic3_decim_ctrl_if.master  smp
);
    localparam int SW = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

    state_t                 state, state_nxt;
    logic [CLOCK_WIDTH-1:0] div_cnt, div_nxt;
    logic [SW-1:0]          settle_cnt;
    logic [NUMBITS-1:0]     data_q;
    logic                   valid_q, ovr_q;
    logic                   active, run_go, cap_stb, settle_last;
    logic                   run_stb, load, drop, xfer;

    assign active      = (state != IDLE);
    assign run_go      = active && enable;
    assign cap_stb     = active && (div_cnt == CLOCK_WIDTH'(CAPTURE_DELAY));
    assign settle_last = (int'(settle_cnt) == SETTLE_SAMPLES - 1);
    assign run_stb     = run_go && (state == RUN) && cap_stb;
    assign xfer        = valid_q && smp.sample_ready;
    assign load        = run_stb && (!valid_q || smp.sample_ready);
    assign drop        = run_stb && valid_q && !smp.sample_ready;
    assign div_nxt     = run_go ? div_cnt + CLOCK_WIDTH'(1) : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
            SETTLE:  if (!enable) state_nxt = IDLE;
                     else if (cap_stb && settle_last) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            div_cnt     <= '0;
            divided_clk <= 1'b0;
            settle_cnt  <= '0;
        end else begin
            state       <= state_nxt;
            div_cnt     <= div_nxt;
            // Factor is a power of two, so "next >= D/2" is just the counter MSB.
            divided_clk <= div_nxt[CLOCK_WIDTH-1];
            if (state == IDLE)
                settle_cnt <= '0;
            else if (run_go && state == SETTLE && cap_stb)
                settle_cnt <= settle_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (load)
                data_q <= cic_out;
            if (!enable)
                valid_q <= 1'b0;
            else if (load)
                valid_q <= 1'b1;
            else if (xfer)
                valid_q <= 1'b0;
            // A drop in the same cycle as a clear must stay visible.
            if (drop)
                ovr_q <= 1'b1;
            else if (smp.overrun_clr)
                ovr_q <= 1'b0;
        end
    end

`ifdef CIC3_DECIM_CTRL_TIMESTAMP_EN
    logic [15:0] seq_cnt, seq_q;

    // Counts every RUN strobe, dropped ones included, so gaps show in the tag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_cnt <= '0;
            seq_q   <= '0;
        end else begin
            if (state == IDLE)
                seq_cnt <= '0;
            else if (run_stb)
                seq_cnt <= seq_cnt + 16'd1;
            if (load)
                seq_q <= seq_cnt;
        end
    end

    assign smp.sample_seq = seq_q;
`endif

    assign busy             = active;
    assign smp.sample_data  = data_q;
    assign smp.sample_valid = valid_q;
    assign smp.overrun      = ovr_q;
endmodule

// File: tb/tb_cic3_decim_ctrl.sv
// Scoreboard bench for cic3_decim_ctrl: random stimulus against a time-based
// reference model; a separate monitor checks every delivered word.
module tb_cic3_decim_ctrl;
    localparam int D  = 16;
    localparam int CD = 4;
    localparam int ST = 3;
    localparam int NB = 13;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [NB-1:0] cic_out = '0;
    logic          divided_clk, busy;

    cic3_decim_ctrl_if #(.NUMBITS(NB)) smp();

    cic3_decim_ctrl #(
        .DECIMATION_FACTOR(D),
        .SETTLE_SAMPLES(ST),
        .CAPTURE_DELAY(CD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .cic_out(cic_out),
        .divided_clk(divided_clk),
        .busy(busy),
        .smp(smp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0] d;
        logic [15:0]   s;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: time since enable, strobe index, one holding slot.
    bit            m_act, m_v, m_ov;
    int            m_t, m_seq;
    logic [NB-1:0] m_d;
    logic [15:0]   m_s;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_v = 0; m_ov = 0; m_t = 0; m_seq = 0; m_d = '0; m_s = '0;
        expq.delete();
    endtask

    task automatic step(input bit en, input bit rdy, input bit clr);
        logic [NB-1:0] cin;
        bit stb, run, ovs;
        @(negedge clk);
        chk("busy", busy, m_act);
        chk("divided_clk", divided_clk, m_act && ((m_t % D) >= D/2));
        chk("sample_valid", smp.sample_valid, m_v);
        chk("overrun", smp.overrun, m_ov);
        if (m_v) chk("held_data", smp.sample_data, m_d);
        cin = NB'($urandom);
        enable = en; smp.sample_ready = rdy; smp.overrun_clr = clr; cic_out = cin;
        if (m_v && rdy) expq.push_back('{m_d, m_s});
        ovs = 0;
        if (!m_act) begin
            if (en) begin m_act = 1; m_t = 0; m_seq = 0; end
        end else if (!en) begin
            m_act = 0; m_v = 0;
        end else begin
            stb = (m_t % D) == CD;
            run = (m_t / D) >= ST;
            if (stb && run) begin
                if (!m_v || rdy) begin m_d = cin; m_s = 16'(m_seq); m_v = 1; end
                else ovs = 1;
                m_seq = (m_seq + 1) % 65536;
            end else if (m_v && rdy) begin
                m_v = 0;
            end
            m_t++;
        end
        if (ovs) m_ov = 1;
        else if (clr) m_ov = 0;
    endtask

    // Monitor: every DUT transfer must match the head of the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && smp.sample_valid && smp.sample_ready) begin
                if (expq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL xfer_unexpected: got data %0h expected no transfer", smp.sample_data);
                end else begin
                    e = expq.pop_front();
                    chk("xfer_data", smp.sample_data, e.d);
`ifdef CIC3_DECIM_CTRL_TIMESTAMP_EN
                    chk("xfer_seq", smp.sample_seq, e.s);
`endif
                end
            end
        end
    end

    initial begin
        int lat;
        int guard;
        smp.sample_ready = 1'b0;
        smp.overrun_clr  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_divclk", divided_clk, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", smp.sample_valid, 0);
        chk("rst_data", smp.sample_data, 0);
        chk("rst_overrun", smp.overrun, 0);
        reset_n = 1'b1;
        repeat (4) step(0, 1, 0);

        // Steady run, ready always high; measure first-word latency
        lat = -1;
        step(1, 1, 0);
        for (int k = 1; k <= 120; k++) begin
            step(1, 1, 0);
            if (lat < 0 && smp.sample_valid) lat = k - 1;
        end
        chk("first_latency", 32'(lat), 3*D + CD + 1);

        // Backpressure: hold, overrun, then drain and clear
        repeat (40) step(1, 0, 0);
        step(1, 1, 0);
        step(1, 1, 1);
        repeat (20) step(1, 1, 0);

        // Ready raised only in the strobe cycle: load and transfer coincide
        repeat (80) step(1, (m_t % D) == CD, 0);

        // Drop enable at div_cnt==10 mid-RUN, then re-enable
        guard = 0;
        while (!(m_act && (m_t / D) >= ST && (m_t % D) == 10) && guard < 200) begin
            step(1, 0, 0);
            guard++;
        end
        chk("reach_div10", 32'(guard < 200), 1);
        step(0, 0, 0);
        repeat (3) step(0, 1, 0);
        repeat (100) step(1, $urandom_range(0, 3) != 0, 0);

        // Random traffic with occasional enable drops and clears
        for (int k = 0; k < 2500; k++)
            step($urandom_range(0, 299) != 0,
                 (k % 600 < 150) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 49) == 0);

        // Asynchronous reset mid-RUN with a held word and overrun set
        repeat (60) step(1, 0, 0);
        chk("pre_rst_valid", smp.sample_valid, 1);
        chk("pre_rst_overrun", smp.overrun, 1);
        #3;
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        chk("arst_divclk", divided_clk, 0);
        chk("arst_busy", busy, 0);
        chk("arst_valid", smp.sample_valid, 0);
        chk("arst_data", smp.sample_data, 0);
        chk("arst_overrun", smp.overrun, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (10) step(0, $urandom_range(0, 1) == 1, 0);
        for (int k = 0; k < 500; k++)
            step($urandom_range(0, 199) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);

        @(negedge clk);
        #4;
        chk("queue_drained", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
